// File: rtl/video_pkg.sv
// Shared timing types and constants for the raster timing generator.
package video_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } axis_timing_t;

  localparam axis_timing_t NES_TIMING_H = '{active: 256, front: 9, sync: 51, back: 25};
  localparam axis_timing_t NES_TIMING_V = '{active: 240, front: 5, sync: 1, back: 16};

  function automatic int unsigned axis_ticks(axis_timing_t t);
    return t.active + t.front + t.sync + t.back;
  endfunction

  function automatic int unsigned ticks_h(axis_timing_t t);
    return axis_ticks(t);
  endfunction

  function automatic int unsigned ticks_v(axis_timing_t t);
    return axis_ticks(t);
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Run control in, registered raster timing out.
interface video_timing_if #(
    parameter int unsigned XW = 9,
    parameter int unsigned YW = 9
);
    logic          I_enable;
    logic          O_pix_en;
    logic          O_active;
    logic          O_hsync;
    logic          O_vsync;
    logic [XW-1:0] O_x;
    logic [YW-1:0] O_y;
    logic          O_line_start;
    logic          O_frame_start;
    logic          O_vblank_start;

    modport master (
        input  I_enable,
        output O_pix_en, O_active, O_hsync, O_vsync, O_x, O_y,
        output O_line_start, O_frame_start, O_vblank_start
    );

    modport slave (
        output I_enable,
        input  O_pix_en, O_active, O_hsync, O_vsync, O_x, O_y,
        input  O_line_start, O_frame_start, O_vblank_start
    );
endinterface

// File: rtl/video_axis_counter.sv
// One raster axis: position counter with wrap, plus active/sync decode of the current position.
module video_axis_counter
    import video_pkg::*;
#(
    parameter axis_timing_t TIMING = NES_TIMING_H,
    parameter int unsigned  W      = 9
) (
    input  logic         I_clock,
    input  logic         I_reset,
    input  logic         I_step,
    output logic [W-1:0] O_count,
    output logic         O_last,
    output logic         O_active,
    output logic         O_sync
);
    localparam int unsigned TOTAL      = axis_ticks(TIMING);
    localparam int unsigned SYNC_START = TIMING.active + TIMING.front;
    localparam int unsigned SYNC_END   = SYNC_START + TIMING.sync;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        O_last   = (count_q == W'(TOTAL - 1));
        O_active = (count_q < W'(TIMING.active));
        O_sync   = (count_q >= W'(SYNC_START)) && (count_q < W'(SYNC_END));
        count_d  = count_q;
        if (I_step) begin
            count_d = O_last ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign O_count = count_q;
endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel divider, h/v axis counters, registered outputs.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned ACTIVE_H  = NES_TIMING_H.active,
    parameter int unsigned FRONT_H   = NES_TIMING_H.front,
    parameter int unsigned SYNC_H    = NES_TIMING_H.sync,
    parameter int unsigned BACK_H    = NES_TIMING_H.back,
    parameter int unsigned ACTIVE_V  = NES_TIMING_V.active,
    parameter int unsigned FRONT_V   = NES_TIMING_V.front,
    parameter int unsigned SYNC_V    = NES_TIMING_V.sync,
    parameter int unsigned BACK_V    = NES_TIMING_V.back,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned PIX_DIV   = 1,
    parameter int unsigned XW        = 9,
    parameter int unsigned YW        = 9
) (
    input logic            I_clock,
    input logic            I_reset,
    video_timing_if.master vid
);
    localparam axis_timing_t TIMING_H = '{active: ACTIVE_H, front: FRONT_H,
                                          sync: SYNC_H, back: BACK_H};
    localparam axis_timing_t TIMING_V = '{active: ACTIVE_V, front: FRONT_V,
                                          sync: SYNC_V, back: BACK_V};
    localparam int unsigned TICKS_H = ticks_h(TIMING_H);
    localparam int unsigned TICKS_V = ticks_v(TIMING_V);
    localparam int unsigned DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    if (PIX_DIV < 1 || FRONT_H < 1 || SYNC_H < 1 || BACK_H < 1 ||
        FRONT_V < 1 || SYNC_V < 1 || BACK_V < 1) begin : g_bad_timing
        $fatal(1, "video_timing_gen: PIX_DIV and all porch/sync lengths must be >= 1");
    end
    if (XW < $clog2(TICKS_H) || YW < $clog2(TICKS_V)) begin : g_bad_width
        $fatal(1, "video_timing_gen: XW/YW too narrow for the line/frame length");
    end

    logic [DW-1:0] div_q, div_d;
    logic          tick;

    always_comb begin
        tick  = vid.I_enable && (div_q == DW'(PIX_DIV - 1));
        div_d = div_q;
        if (vid.I_enable) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) div_q <= '0;
        else          div_q <= div_d;
    end

    logic [XW-1:0] h_count;
    logic [YW-1:0] v_count;
    logic          h_last, h_active, h_sync;
    logic          v_last, v_active, v_sync;

    video_axis_counter #(.TIMING(TIMING_H), .W(XW)) u_h_axis (
        .I_clock  (I_clock),
        .I_reset  (I_reset),
        .I_step   (tick),
        .O_count  (h_count),
        .O_last   (h_last),
        .O_active (h_active),
        .O_sync   (h_sync)
    );

    // Vertical axis only moves on the tick that wraps the line.
    video_axis_counter #(.TIMING(TIMING_V), .W(YW)) u_v_axis (
        .I_clock  (I_clock),
        .I_reset  (I_reset),
        .I_step   (tick && h_last),
        .O_count  (v_count),
        .O_last   (v_last),
        .O_active (v_active),
        .O_sync   (v_sync)
    );

    logic          pix_en_q, active_q, hsync_q, vsync_q;
    logic          line_start_q, frame_start_q, vblank_start_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    // Counters hold the pixel about to be shown; a tick latches its decode and advances.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            pix_en_q       <= 1'b0;
            active_q       <= 1'b0;
            hsync_q        <= !HSYNC_POL;
            vsync_q        <= !VSYNC_POL;
            x_q            <= '0;
            y_q            <= '0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            pix_en_q       <= tick;
            line_start_q   <= tick && (h_count == '0);
            frame_start_q  <= tick && (h_count == '0) && (v_count == '0);
            vblank_start_q <= tick && (h_count == '0) && (v_count == YW'(ACTIVE_V));
            if (tick) begin
                x_q      <= h_count;
                y_q      <= v_count;
                active_q <= h_active && v_active;
                hsync_q  <= h_sync ? HSYNC_POL : !HSYNC_POL;
                vsync_q  <= v_sync ? VSYNC_POL : !VSYNC_POL;
            end
        end
    end

    assign vid.O_pix_en       = pix_en_q;
    assign vid.O_active       = active_q;
    assign vid.O_hsync        = hsync_q;
    assign vid.O_vsync        = vsync_q;
    assign vid.O_x            = x_q;
    assign vid.O_y            = y_q;
    assign vid.O_line_start   = line_start_q;
    assign vid.O_frame_start  = frame_start_q;
    assign vid.O_vblank_start = vblank_start_q;

    logic unused_v_last;
    assign unused_v_last = v_last;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: default NES timing (directed enable/reset steps) alongside a small PIX_DIV=4 instance
// with random enable, both checked every cycle against an arithmetic pixel-index model.
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    video_timing_if #(.XW(9), .YW(9)) vif_a ();
    video_timing_if #(.XW(5), .YW(4)) vif_b ();

    video_timing_gen u_dut_a (
        .I_clock (clk),
        .I_reset (rst_n),
        .vid     (vif_a)
    );

    video_timing_gen #(
        .ACTIVE_H(12), .FRONT_H(2), .SYNC_H(3), .BACK_H(2),
        .ACTIVE_V(6),  .FRONT_V(1), .SYNC_V(2), .BACK_V(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_DIV(4), .XW(5), .YW(4)
    ) u_dut_b (
        .I_clock (clk),
        .I_reset (rst_n),
        .vid     (vif_b)
    );

    localparam int AH [2] = '{256, 12};
    localparam int FH [2] = '{9, 2};
    localparam int SH [2] = '{51, 3};
    localparam int BH [2] = '{25, 2};
    localparam int AV [2] = '{240, 6};
    localparam int FV [2] = '{5, 1};
    localparam int SV [2] = '{1, 2};
    localparam int BV [2] = '{16, 1};
    localparam bit HP [2] = '{1'b0, 1'b1};
    localparam bit VP [2] = '{1'b0, 1'b1};
    localparam int DV [2] = '{1, 4};

    typedef struct {
        bit pix_en, active, hsync, vsync, ls, fs, vb;
        int x, y;
    } vout_t;

    vout_t  mdl [2];
    longint en_cnt [2];
    longint pix_cnt [2];
    int     checks = 0;
    int     errors = 0;
    bit     en_a = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic model_reset(input int i);
        en_cnt[i]  = 0;
        pix_cnt[i] = 0;
        mdl[i] = '{pix_en: 1'b0, active: 1'b0, hsync: !HP[i], vsync: !VP[i],
                   ls: 1'b0, fs: 1'b0, vb: 1'b0, x: 0, y: 0};
    endtask

    // The n-th enabled clock is a pixel tick when n is a multiple of the divide; tick k shows
    // raster pixel k, laid out line by line.
    task automatic model_step(input int i, input bit e);
        longint p;
        int th, tv, px, py;
        th = AH[i] + FH[i] + SH[i] + BH[i];
        tv = AV[i] + FV[i] + SV[i] + BV[i];
        mdl[i].pix_en = 1'b0;
        mdl[i].ls = 1'b0;
        mdl[i].fs = 1'b0;
        mdl[i].vb = 1'b0;
        if (e) begin
            en_cnt[i]++;
            if (en_cnt[i] % DV[i] == 0) begin
                p = pix_cnt[i];
                pix_cnt[i]++;
                px = int'(p % th);
                py = int'((p / th) % tv);
                mdl[i].pix_en = 1'b1;
                mdl[i].x = px;
                mdl[i].y = py;
                mdl[i].active = (px < AH[i]) && (py < AV[i]);
                mdl[i].hsync = (px >= AH[i] + FH[i] && px < AH[i] + FH[i] + SH[i]) ? HP[i] : !HP[i];
                mdl[i].vsync = (py >= AV[i] + FV[i] && py < AV[i] + FV[i] + SV[i]) ? VP[i] : !VP[i];
                mdl[i].ls = (px == 0);
                mdl[i].fs = (px == 0) && (py == 0);
                mdl[i].vb = (px == 0) && (py == AV[i]);
            end
        end
    endtask

    task automatic cmp_inst(input int i, input logic pe, act, hs, vs, ls, fs, vb,
                            input logic [31:0] x, y);
        string p;
        p = (i == 0) ? "a" : "b";
        chk({p, ".pix_en"}, 32'(pe), 32'(mdl[i].pix_en));
        chk({p, ".active"}, 32'(act), 32'(mdl[i].active));
        chk({p, ".hsync"}, 32'(hs), 32'(mdl[i].hsync));
        chk({p, ".vsync"}, 32'(vs), 32'(mdl[i].vsync));
        chk({p, ".line_start"}, 32'(ls), 32'(mdl[i].ls));
        chk({p, ".frame_start"}, 32'(fs), 32'(mdl[i].fs));
        chk({p, ".vblank_start"}, 32'(vb), 32'(mdl[i].vb));
        chk({p, ".x"}, x, 32'(mdl[i].x));
        chk({p, ".y"}, y, 32'(mdl[i].y));
    endtask

    task automatic cmp_all();
        cmp_inst(0, vif_a.O_pix_en, vif_a.O_active, vif_a.O_hsync, vif_a.O_vsync,
                 vif_a.O_line_start, vif_a.O_frame_start, vif_a.O_vblank_start,
                 32'(vif_a.O_x), 32'(vif_a.O_y));
        cmp_inst(1, vif_b.O_pix_en, vif_b.O_active, vif_b.O_hsync, vif_b.O_vsync,
                 vif_b.O_line_start, vif_b.O_frame_start, vif_b.O_vblank_start,
                 32'(vif_b.O_x), 32'(vif_b.O_y));
    endtask

    // One clock: drive reset/enables on the falling edge, check 1 ns after the rising edge.
    task automatic step(input bit rst_val);
        bit e_b;
        @(negedge clk);
        e_b = ($urandom_range(0, 3) != 0);
        rst_n = rst_val;
        vif_a.I_enable = en_a;
        vif_b.I_enable = e_b;
        if (!rst_val) begin
            #1;
            model_reset(0);
            model_reset(1);
            cmp_all();
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, en_a);
            model_step(1, e_b);
        end
        cmp_all();
    endtask

    initial begin
        int budget;
        int hs_low;
        int ls_cnt;
        vif_a.I_enable = 1'b0;
        vif_b.I_enable = 1'b0;
        model_reset(0);
        model_reset(1);
        for (int i = 0; i < 3; i++) step(1'b0);
        chk("a.reset_hsync", 32'(vif_a.O_hsync), 32'd1);
        chk("b.reset_hsync", 32'(vif_b.O_hsync), 32'd0);

        en_a = 1'b1;
        step(1'b1);
        chk("a.first_frame_start", 32'(vif_a.O_frame_start), 32'd1);
        chk("a.first_active", 32'(vif_a.O_active), 32'd1);

        // Run default instance to pixel (100,50), tallying line-0 hsync and line starts.
        hs_low = 0;
        ls_cnt = 1;
        budget = 60000;
        while (!(mdl[0].pix_en && mdl[0].x == 100 && mdl[0].y == 50) && budget > 0) begin
            step(1'b1);
            budget--;
            if (vif_a.O_pix_en && vif_a.O_y == 0 && !vif_a.O_hsync) hs_low++;
            if (vif_a.O_line_start) ls_cnt++;
        end
        if (budget == 0) chk("a.reach_100_50", 32'd0, 32'd1);
        chk("a.hsync_ticks_line0", 32'(hs_low), 32'd51);
        chk("a.line_starts_to_y50", 32'(ls_cnt), 32'd51);

        en_a = 1'b0;
        for (int i = 0; i < 17; i++) step(1'b1);
        chk("a.freeze_x", 32'(vif_a.O_x), 32'd100);
        chk("a.freeze_y", 32'(vif_a.O_y), 32'd50);
        en_a = 1'b1;
        step(1'b1);
        chk("a.resume_pix_en", 32'(vif_a.O_pix_en), 32'd1);
        chk("a.resume_x", 32'(vif_a.O_x), 32'd101);

        budget = 60000;
        while (!(mdl[0].pix_en && mdl[0].x == 200 && mdl[0].y == 120) && budget > 0) begin
            step(1'b1);
            budget--;
        end
        if (budget == 0) chk("a.reach_200_120", 32'd0, 32'd1);

        for (int i = 0; i < 3; i++) step(1'b0);
        chk("a.midreset_x", 32'(vif_a.O_x), 32'd0);
        step(1'b1);
        chk("a.post_reset_frame_start", 32'(vif_a.O_frame_start), 32'd1);
        chk("a.post_reset_y", 32'(vif_a.O_y), 32'd0);

        for (int i = 0; i < 2000; i++) step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator, successor to the fixed 256x240 timing block. Produces pixel-enable, sync, active-video, pixel coordinates, line/frame strobes and a vblank-start event for the PPU/scan-out path. Porch/sync lengths, sync polarity and pixel clock divide are generic. Adds run/pause control. All outputs are registered and mutually aligned.

Parameters:
ACTIVE_H, 256, visible pixels per line
FRONT_H, 9, horizontal front porch (pixel ticks)
SYNC_H, 51, horizontal sync width
BACK_H, 25, horizontal back porch
ACTIVE_V, 240, visible lines per frame
FRONT_V, 5, vertical front porch (lines)
SYNC_V, 1, vertical sync width
BACK_V, 16, vertical back porch
HSYNC_POL, 0, asserted level of O_hsync (0 = active-low)
VSYNC_POL, 0, asserted level of O_vsync
PIX_DIV, 1, I_clock cycles per pixel tick (>=1)
XW, 9, width of O_x, >= clog2(ACTIVE_H+FRONT_H+SYNC_H+BACK_H)
YW, 9, width of O_y, >= clog2(ACTIVE_V+FRONT_V+SYNC_V+BACK_V)

Ports:
I_clock  in  1  system clock
I_reset  in  1  asynchronous, active-low reset
I_enable  in  1  1 = run; 0 = freeze counters and divider (outputs hold)
O_pix_en  out  1  one-I_clock pulse per pixel tick; qualifies all other outputs
O_active  out  1  1 when (x<ACTIVE_H && y<ACTIVE_V)
O_hsync  out  1  horizontal sync at HSYNC_POL level during sync interval
O_vsync  out  1  vertical sync at VSYNC_POL level during sync lines
O_x  out  XW  current horizontal position, 0..TICKS_H-1
O_y  out  YW  current line, 0..TICKS_V-1
O_line_start  out  1  pulse with O_pix_en when x==0
O_frame_start  out  1  pulse with O_pix_en when x==0 && y==0
O_vblank_start  out  1  pulse with O_pix_en when x==0 && y==ACTIVE_V (PPU NMI source)

Behaviour:
- Reset I_reset, asynchronous, active-low; clock I_clock. Everything else synchronous to rising I_clock.
- TICKS_H = ACTIVE_H+FRONT_H+SYNC_H+BACK_H (341 default); TICKS_V = sum of V terms (262 default).
- Line layout: active [0,ACTIVE_H), front porch, sync [ACTIVE_H+FRONT_H, ACTIVE_H+FRONT_H+SYNC_H), back porch. Same ordering vertically in lines.
- Divider: div counter 0..PIX_DIV-1; tick when div==PIX_DIV-1 and I_enable=1; with PIX_DIV=1 tick every enabled clock.
- On tick: x advances; at x==TICKS_H-1 x wraps to 0 and y advances; at y==TICKS_V-1 with x wrap, y wraps to 0.
- Outputs registered: decoded from the counter state being entered, so O_x/O_y and every flag describe the same pixel in the same cycle; O_pix_en high the cycle after the tick (1-cycle latency from tick, constant).
- Strobes are single-cycle, coincident with O_pix_en; never asserted while O_pix_en=0.
- I_enable=0: div, x, y frozen; O_pix_en and strobes 0; level outputs (sync, active, x, y) hold. Resume continues from frozen position with no skipped or repeated pixel.
- Reset values: div=0, x=0, y=0; O_pix_en=0, strobes=0, O_active=0, O_x=0, O_y=0, O_hsync=!HSYNC_POL, O_vsync=!VSYNC_POL. First tick after reset release presents x=0,y=0 with O_frame_start=1, O_line_start=1, O_active=1.
- Reset mid-frame: immediate return to reset values; no partial strobe.
- Elaboration check: PIX_DIV>=1, all porch/sync >=1, XW/YW wide enough; fail elaboration otherwise.

Decomposition:
- Package video_pkg: timing record typedef (active/front/sync/back per axis), default NES timing constants, TICKS_H/TICKS_V helper functions.
- Sub-module video_axis_counter (one per axis: count, wrap, sync/active decode), instantiated twice; vertical instance advanced by horizontal wrap.

Test Plan:
- Defaults, release reset, run 2 frames -> O_pix_en every clock; x wraps 340->0; y wraps 261->0; exactly 341*262=89342 ticks between O_frame_start pulses.
- Defaults -> O_hsync low exactly for x in [265,316) (51 ticks/line); O_vsync low only for y==245; O_active count per frame = 61440.
- Defaults -> O_vblank_start single pulse per frame at x=0,y=240; O_line_start 262 pulses per frame.
- PIX_DIV=4, HSYNC_POL=1 -> O_pix_en every 4th clock; O_x constant for 4 clocks; O_hsync high during sync.
- I_enable low 17 clocks at x=100,y=50 -> no pix_en/strobes, x/y hold; after release next pixel x=101.
- Assert I_reset at x=200,y=120 -> outputs at reset values same cycle; after release first pixel x=0,y=0 with O_frame_start=1.
